ad_capture_ctrl: RTL

- Triggered capture sequencer for the dual-channel 12-bit AD path.
- Takes the registered ad_ch1/ad_ch2 samples and waits for a level/edge trigger on a selected channel, at a programmable decimation rate.
- Stores a fixed-length record of both channels in internal block RAM.
- Streams the record out over a valid/ready handshake to the UART formatter, which shares the readout.

---
 rtl/ad_capture_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ad_capture_ctrl.sv
// ad_capture_ctrl: triggered capture sequencer for the dual-channel 12-bit AD path.
// Waits for a level/edge trigger on the selected channel at a programmable
// decimation rate. It then records 2^DEPTH_LOG2 {ch1, ch2} pairs into block RAM
// and streams them out over a valid/ready handshake.
// Optional feature macro: ADC_AUTO_TRIG_EN. When it is defined, a timeout in
// WAIT_TRIG forces a trigger and raises trig_forced. When it is undefined, the
// block waits for a real trigger indefinitely and trig_forced is tied low.

module ad_capture_ctrl #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DECIM_W    = 16,
  parameter int TIMEOUT    = 50000000
) (
  input  logic               clk50m,
  input  logic               reset_n,
  input  logic [11:0]        ad_ch1,
  input  logic [11:0]        ad_ch2,
  input  logic               arm,
  input  logic               trig_sel,
  input  logic               trig_edge,
  input  logic [11:0]        trig_level,
  input  logic [DECIM_W-1:0] decim,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [23:0]        rd_data,
  output logic               rd_last,
  output logic               busy,
  output logic               trig_forced
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_CAPTURE,
    S_READOUT
  } state_t;

  // One extra MSB: when it is set, every address has been used, so no wrap compare is needed.
  typedef logic [DEPTH_LOG2:0] addr_t;

  state_t               state_q;
  logic [DECIM_W-1:0]   decim_q;
  logic [DECIM_W-1:0]   dcnt_q;
  logic                 trig_sel_q;
  logic                 trig_edge_q;
  logic [11:0]          level_q;
  logic [11:0]          prev_q;
  logic                 prev_vld_q;
  addr_t                wr_addr_q;
  addr_t                rd_addr_q;
  logic                 rd_valid_q;
  logic                 rd_last_q;
  logic [23:0]          rd_data_q;
  logic                 busy_q;

  logic [23:0]          mem [DEPTH];

  logic                  strobe;
  logic [11:0]           cur;
  logic                  crossed;
  logic                  real_trig;
  logic                  force_trig;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  addr_t                 wr_addr_nxt;
  logic                  rd_en;
  logic [23:0]           pair;

  // Decimation strobe, trigger detection, RAM write/read enables.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    strobe      = 1'b0;
    cur         = 12'h000;
    crossed     = 1'b0;
    real_trig   = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = '0;
    wr_addr_nxt = wr_addr_q + 1'b1;
    rd_en       = 1'b0;
    pair        = {ad_ch1, ad_ch2};

    strobe = ((state_q == S_WAIT_TRIG) || (state_q == S_CAPTURE)) && (dcnt_q == decim_q);
    cur    = trig_sel_q ? ad_ch2 : ad_ch1;
    if (trig_edge_q) crossed = (prev_q > level_q) && (cur <= level_q);
    else             crossed = (prev_q < level_q) && (cur >= level_q);
    // The first strobe after arm only primes prev_q.
    real_trig = strobe && (state_q == S_WAIT_TRIG) && prev_vld_q && crossed;

    wr_en  = strobe && (((state_q == S_WAIT_TRIG) && (real_trig || force_trig)) ||
                        (state_q == S_CAPTURE));
    wr_idx = (state_q == S_WAIT_TRIG) ? '0 : wr_addr_q[DEPTH_LOG2-1:0];

    // Fetch the next word whenever the output register is empty or is being drained.
    rd_en = (state_q == S_READOUT) && !rd_addr_q[DEPTH_LOG2] && (!rd_valid_q || rd_ready);
  end

`ifdef ADC_AUTO_TRIG_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             trig_forced_q;
  logic             tmo_hit;

  assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign force_trig = strobe && (state_q == S_WAIT_TRIG) && tmo_hit;

  // WAIT_TRIG timeout: cleared on arm and saturating at TIMEOUT-1, so the next strobe is forced.
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q         <= '0;
      trig_forced_q <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && arm)                tmo_q <= '0;
      else if ((state_q == S_WAIT_TRIG) && !tmo_hit) tmo_q <= tmo_q + 1'b1;
      // A real crossing on the same strobe wins over the timeout.
      if ((state_q == S_WAIT_TRIG) && (real_trig || force_trig))
        trig_forced_q <= !real_trig;
    end
  end

  assign trig_forced = trig_forced_q;
`else
  logic unused_timeout;

  assign force_trig     = 1'b0;
  assign trig_forced    = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Capture RAM write port.
  // NOTE: the RAM array has no reset; block RAM cannot be cleared in one cycle, and every word
  // that is read out is first written by the current record.
  always_ff @(posedge clk50m) begin
    if (wr_en) mem[wr_idx] <= pair;
  end

  // Sequencer: arm/trigger/capture/readout, with registered handshake outputs.
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      decim_q     <= '0;
      dcnt_q      <= '0;
      trig_sel_q  <= 1'b0;
      trig_edge_q <= 1'b0;
      level_q     <= 12'h000;
      prev_q      <= 12'h000;
      prev_vld_q  <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= 24'h000000;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments only, so every read sees the pre-edge value.
      if ((state_q == S_WAIT_TRIG) || (state_q == S_CAPTURE)) begin
        dcnt_q <= strobe ? '0 : dcnt_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (arm) begin
            decim_q     <= decim;
            trig_sel_q  <= trig_sel;
            trig_edge_q <= trig_edge;
            level_q     <= trig_level;
            dcnt_q      <= '0;
            prev_vld_q  <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_WAIT_TRIG;
          end
        end

        S_WAIT_TRIG: begin
          if (strobe) begin
            prev_q     <= cur;
            prev_vld_q <= 1'b1;
            if (real_trig || force_trig) begin
              // Address 0 was written by this strobe.
              wr_addr_q <= addr_t'(1);
              state_q   <= S_CAPTURE;
            end
          end
        end

        S_CAPTURE: begin
          if (strobe) begin
            wr_addr_q <= wr_addr_nxt;
            if (wr_addr_nxt[DEPTH_LOG2]) begin
              rd_addr_q <= '0;
              state_q   <= S_READOUT;
            end
          end
        end

        S_READOUT: begin
          if (rd_en) begin
            rd_data_q  <= mem[rd_addr_q[DEPTH_LOG2-1:0]];
            rd_last_q  <= (rd_addr_q == addr_t'(DEPTH - 1));
            rd_valid_q <= 1'b1;
            rd_addr_q  <= rd_addr_q + 1'b1;
          end else if (rd_valid_q && rd_ready) begin
            // Only the final word can drain without a refill behind it.
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            if (rd_last_q) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;
  assign busy     = busy_q;

endmodule
